// File: rtl/spi_ram_gen_if.sv
// spi_ram_gen command/response bundle.
// Master drives commands and tx_ready; slave returns read data.
interface spi_ram_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              busy;
  logic              err;

  modport master (
    output din, rx_valid, tx_ready,
    input  dout, tx_valid, busy, err
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output dout, tx_valid, busy, err
  );
endinterface

// File: rtl/spi_ram_gen.sv
// Command-driven RAM with a one-word read handshake.
// Define SPI_RAM_AUTOINC_EN to auto-increment both pointers.
module spi_ram_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          rst,
  spi_ram_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] INC = '0;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                tx_valid_q, tx_valid_d;
  logic                err_q, err_d;
  logic                we;
  logic [DATA_W-1:0]   mem_q [2**ADDR_W];

  logic [1:0]          op;
  logic [DATA_W-1:0]   pl;
  logic                rd_cmd;

  assign op     = bus.din[DATA_W+1:DATA_W];
  assign pl     = bus.din[DATA_W-1:0];
  assign rd_cmd = bus.rx_valid && (op == OP_RD);

  // Next state: read FSM, pointer updates, drop detection.
  // Pointer loads come last so they override the fetch increment.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    we         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_cmd) state_d = FETCH;
      end
      FETCH: begin
        dout_d     = mem_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + INC;
        tx_valid_d = 1'b1;
        state_d    = HOLD;
      end
      HOLD: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rd_cmd && (state_q != IDLE)) err_d = 1'b1;
    if (bus.rx_valid) begin
      unique case (op)
        OP_WA: wr_ptr_d = pl[ADDR_W-1:0];
        OP_WD: begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + INC;
        end
        OP_RA: rd_ptr_d = pl[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage array; contents survive reset, writes blocked during it.
  always_ff @(posedge clk) begin
    if (!rst && we) mem_q[wr_ptr_q] <= pl;
  end

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.err      = err_q;

endmodule

// File: tb/tb_spi_ram_gen.sv
// Scoreboard bench for spi_ram_gen (DATA_W=8, ADDR_W=8).
// Expectations follow SPI_RAM_AUTOINC_EN when defined.
module tb_spi_ram_gen;

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif

  logic clk = 1'b0;
  logic rst;

  spi_ram_gen_if #(.DATA_W(8)) bus ();

  spi_ram_gen #(
    .DATA_W(8),
    .ADDR_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] mem_m [256];
  logic [7:0] wr_m;
  logic [7:0] rd_m;
  logic [7:0] q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [9:0] c);
    case (c[9:8])
      2'b00: wr_m = c[7:0];
      2'b01: begin
        mem_m[wr_m] = c[7:0];
        wr_m = wr_m + INC;
      end
      2'b10: rd_m = c[7:0];
      default: ;
    endcase
  endtask

  task automatic cmd(input logic [9:0] c);
    bus.din = c;
    bus.rx_valid = 1'b1;
    model(c);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic rd(input int hold, input bit fc_en,
                    input logic [9:0] fc, input bit coll);
    logic [7:0] d0;
    logic [7:0] e;
    int n;
    bus.din = 10'h300;
    bus.rx_valid = 1'b1;
    q.push_back(mem_m[rd_m]);
    rd_m = rd_m + INC;
    @(posedge clk);
    #1;
    if (fc_en) begin
      bus.din = fc;
      bus.rx_valid = 1'b1;
      model(fc);
    end else begin
      bus.rx_valid = 1'b0;
    end
    chk("fetch_busy", 32'(bus.busy), 1);
    chk("fetch_txv", 32'(bus.tx_valid), 0);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    n = 0;
    while (!bus.tx_valid && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 0);
    d0 = bus.dout;
    e = q.pop_front();
    chk("rdata", 32'(d0), 32'(e));
    for (int i = 0; i < hold; i++) begin
      if (coll && i == 0) begin
        bus.din = 10'h300;
        bus.rx_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      if (coll && i == 0) chk("err_hi", 32'(bus.err), 1);
      if (coll && i == 1) chk("err_lo", 32'(bus.err), 0);
      chk("hold_txv", 32'(bus.tx_valid), 1);
      chk("hold_dout", 32'(bus.dout), 32'(d0));
    end
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    chk("done_txv", 32'(bus.tx_valid), 0);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_dout", 32'(bus.dout), 32'(d0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    wr_m = 8'h00;
    rd_m = 8'h00;
    bus.tx_ready = 1'b0;

    // reset with a simultaneous read command
    rst = 1'b1;
    bus.rx_valid = 1'b1;
    bus.din = 10'h3FF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_txv", 32'(bus.tx_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    @(posedge clk);
    #1;
    chk("rst_busy2", 32'(bus.busy), 0);

    // single access with three stall cycles
    cmd(10'h010);
    cmd(10'h1A5);
    cmd(10'h210);
    rd(3, 1'b0, 10'h000, 1'b0);

    // collision while holding
    cmd(10'h011);
    cmd(10'h1B6);
    cmd(10'h210);
    rd(3, 1'b0, 10'h000, 1'b1);
    rd(1, 1'b0, 10'h000, 1'b0);

    // burst write across the top of memory
    cmd(10'h0FE);
    cmd(10'h111);
    cmd(10'h122);
    cmd(10'h133);
    cmd(10'h2FE);
    rd(0, 1'b0, 10'h000, 1'b0);
    rd(0, 1'b0, 10'h000, 1'b0);
    rd(0, 1'b0, 10'h000, 1'b0);

    // fixed pointer / incrementing pointer reads
    cmd(10'h005);
    cmd(10'h1C3);
    cmd(10'h13C);
    cmd(10'h205);
    rd(0, 1'b0, 10'h000, 1'b0);
    rd(0, 1'b0, 10'h000, 1'b0);

    // RD_ADDR on the fetch edge overrides the increment
    cmd(10'h2FE);
    rd(0, 1'b1, 10'h205, 1'b0);
    rd(0, 1'b0, 10'h000, 1'b0);

    // write to the fetched word on the fetch edge
    cmd(10'h040);
    cmd(10'h1AA);
    cmd(10'h040);
    cmd(10'h240);
    rd(0, 1'b1, 10'h155, 1'b0);
    cmd(10'h240);
    rd(0, 1'b0, 10'h000, 1'b0);

    // reset during fetch
    bus.din = 10'h300;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_m = 8'h00;
    rd_m = 8'h00;
    chk("mid_txv", 32'(bus.tx_valid), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mid_txv_stay", 32'(bus.tx_valid), 0);
    end

    // memory survives reset
    cmd(10'h240);
    rd(0, 1'b0, 10'h000, 1'b0);

    chk("q_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
